fifo_wr_packer: RTL and testbench

//  Write-side packer feeding the async FIFO write port in the wr_clk domain.

---
 rtl/fifo_wr_packer.sv | 127 ++++++++++++
 tb/tb_fifo_wr_packer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_packer.sv
// Write-side packer: folds PACK_RATIO narrow beats into one {last, beats-1, lanes} FIFO word.
// Optional partial-word idle flush is enabled by defining FIFO_WR_PACKER_TIMEOUT_EN.
module fifo_wr_packer #(
  parameter  int IN_WIDTH       = 8,
  parameter  int PACK_RATIO     = 4,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int CNT_W          = $clog2(PACK_RATIO),
  localparam int LANES_W        = PACK_RATIO * IN_WIDTH,
  localparam int DATA_W         = LANES_W + CNT_W + 1
) (
  input  logic                wr_clk,
  input  logic                wr_rst_n,
  input  logic                s_valid,
  input  logic [IN_WIDTH-1:0] s_data,
  input  logic                s_last,
  output logic                s_ready,
  output logic                fifo_wr_en,
  output logic [DATA_W-1:0]   fifo_wr_data,
  input  logic                fifo_wr_full
);

  // Reject parameter sets the lane/count encoding cannot represent.
  if ((PACK_RATIO < 2) || ((PACK_RATIO & (PACK_RATIO - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("fifo_wr_packer: PACK_RATIO must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [LANES_W-1:0] lanes_q, lanes_d, lanes_ins_s;
  logic [CNT_W-1:0]   lane_cnt_q, lane_cnt_d;
  logic               out_pend_q, out_pend_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               accept_s, drain_s, close_s, flush_s;

  assign s_ready      = ~out_pend_q | ~fifo_wr_full;
  assign drain_s      = out_pend_q & ~fifo_wr_full;
  assign accept_s     = s_valid & s_ready;
  assign close_s      = s_last | (lane_cnt_q == CNT_W'(PACK_RATIO - 1));
  assign fifo_wr_en   = drain_s;
  assign fifo_wr_data = out_data_q;

  // Accumulator with the incoming beat steered into lane lane_cnt_q.
  always_comb begin
    lanes_ins_s = lanes_q;
    for (int k = 0; k < PACK_RATIO; k++) begin
      if (lane_cnt_q == CNT_W'(k)) begin
        lanes_ins_s[k*IN_WIDTH +: IN_WIDTH] = s_data;
      end else begin
        lanes_ins_s[k*IN_WIDTH +: IN_WIDTH] = lanes_q[k*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

`ifdef FIFO_WR_PACKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              partial_s;

  assign partial_s = (lane_cnt_q != {CNT_W{1'b0}});
  // A flush may only load the output register if it is free or draining this cycle.
  assign flush_s   = partial_s & ~accept_s & (~out_pend_q | drain_s) &
                     (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES));

  // Idle counter: saturating, cleared by any accepted beat or flush.
  always_comb begin
    if (accept_s | flush_s | ~partial_s) begin
      idle_cnt_d = {IDLE_W{1'b0}};
    end else if (idle_cnt_q != IDLE_W'(TIMEOUT_CYCLES)) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end

  // Idle counter register.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      idle_cnt_q <= {IDLE_W{1'b0}};
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign flush_s = 1'b0;
`endif

  // Next-state: beat accept / word close, partial flush, or hold; a close during a drain replaces the word.
  always_comb begin
    lanes_d    = lanes_q;
    lane_cnt_d = lane_cnt_q;
    out_data_d = out_data_q;
    out_pend_d = out_pend_q & ~drain_s;
    if (accept_s) begin
      if (close_s) begin
        out_data_d = {s_last, lane_cnt_q, lanes_ins_s};
        out_pend_d = 1'b1;
        lane_cnt_d = {CNT_W{1'b0}};
        lanes_d    = {LANES_W{1'b0}};
      end else begin
        lane_cnt_d = lane_cnt_q + CNT_W'(1);
        lanes_d    = lanes_ins_s;
      end
    end else if (flush_s) begin
      out_data_d = {1'b0, lane_cnt_q - CNT_W'(1), lanes_q};
      out_pend_d = 1'b1;
      lane_cnt_d = {CNT_W{1'b0}};
      lanes_d    = {LANES_W{1'b0}};
    end else begin
      lanes_d = lanes_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      lanes_q    <= {LANES_W{1'b0}};
      lane_cnt_q <= {CNT_W{1'b0}};
      out_pend_q <= 1'b0;
      out_data_q <= {DATA_W{1'b0}};
    end else begin
      lanes_q    <= lanes_d;
      lane_cnt_q <= lane_cnt_d;
      out_pend_q <= out_pend_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer (IN_WIDTH=8, PACK_RATIO=4, DATA_W=35).
// Define FIFO_WR_PACKER_TIMEOUT_EN for both bench and RTL to test the idle flush.
module tb_fifo_wr_packer;

  logic        wr_clk = 1'b0;
  logic        wr_rst_n;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        fifo_wr_en;
  logic [34:0] fifo_wr_data;
  logic        fifo_wr_full;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [34:0] wq[$];
  int          wstamp[$];

  fifo_wr_packer #(.IN_WIDTH(8), .PACK_RATIO(4), .TIMEOUT_CYCLES(16)) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full)
  );

  always #5 wr_clk = ~wr_clk;

  // Inputs change just after posedge, so the negedge view is what the next posedge sees.
  always @(negedge wr_clk) begin
    cyc = cyc + 1;
    if (fifo_wr_en && !fifo_wr_full) begin
      wq.push_back(fifo_wr_data);
      wstamp.push_back(cyc);
    end
    checks++;
    if (fifo_wr_en && fifo_wr_full) begin
      errors++;
      $display("FAIL wr_en_while_full: fifo_wr_en=%b fifo_wr_full=%b required wr_en=0", fifo_wr_en, fifo_wr_full);
    end
  end

  function automatic logic [34:0] mk(input logic l, input logic [1:0] c, input logic [31:0] d);
    return {l, c, d};
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge wr_clk);
      #1;
    end
  endtask

  task automatic clear_log();
    wq.delete();
    wstamp.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic acc;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge wr_clk);
      acc = s_ready;
      @(posedge wr_clk);
      #1;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: beat %h not accepted within 50 cycles, required accept", d);
    end
  endtask

  task automatic do_reset();
    s_valid  = 1'b0;
    s_last   = 1'b0;
    wr_rst_n = 1'b0;
    tick(2);
    wr_rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    wr_rst_n = 1'b0;
    @(negedge wr_clk);
    checks++;
    if (fifo_wr_en !== 1'b0 || fifo_wr_data !== 35'h0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: wr_en=%b data=%h ready=%b required 0/0/1", fifo_wr_en, fifo_wr_data, s_ready);
    end
    @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_full_words();
    int nready;
    nready = 0;
    clear_log();
    s_valid = 1'b1;
    s_last  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s_data = 8'h11 * 8'(k + 1);
      @(negedge wr_clk);
      if (s_ready !== 1'b1) nready++;
      @(posedge wr_clk);
      #1;
    end
    s_valid = 1'b0;
    tick(4);
    checks++;
    if (nready != 0) begin
      errors++;
      $display("FAIL full_words_ready: ready low %0d cycles, required 0", nready);
    end
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL full_words_count: got %0d writes, required 2", wq.size());
    end else begin
      checks++;
      if (wq[0] !== mk(1'b0, 2'd3, 32'h44332211)) begin
        errors++;
        $display("FAIL full_words_w0: got %h required %h", wq[0], mk(1'b0, 2'd3, 32'h44332211));
      end
      checks++;
      if (wq[1] !== mk(1'b0, 2'd3, 32'h88776655)) begin
        errors++;
        $display("FAIL full_words_w1: got %h required %h", wq[1], mk(1'b0, 2'd3, 32'h88776655));
      end
    end
  endtask

  task automatic test_short_last();
    clear_log();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge wr_clk);
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== mk(1'b1, 2'd2, 32'h00A3A2A1)) begin
      errors++;
      $display("FAIL short_last_latency: wr_en=%b data=%h required 1/%h", fifo_wr_en, fifo_wr_data, mk(1'b1, 2'd2, 32'h00A3A2A1));
    end
    tick(4);
    checks++;
    if (wq.size() != 1) begin
      errors++;
      $display("FAIL short_last_count: got %0d writes, required 1", wq.size());
    end
  endtask

  task automatic test_full_hold();
    int   i;
    int   en_seen;
    logic r;
    i       = 0;
    en_seen = 0;
    clear_log();
    fifo_wr_full = 1'b1;
    s_valid = 1'b1;
    s_last  = 1'b0;
    s_data  = 8'h31;
    for (int c = 0; c < 10; c++) begin
      @(negedge wr_clk);
      r = s_ready;
      if (fifo_wr_en) en_seen++;
      @(posedge wr_clk);
      #1;
      if (r) begin
        i++;
        s_data = 8'h31 + 8'(i);
      end
    end
    @(negedge wr_clk);
    checks++;
    if (i != 4 || s_ready !== 1'b0 || en_seen != 0) begin
      errors++;
      $display("FAIL full_hold_stall: accepted=%0d ready=%b wr_en_cycles=%0d required 4/0/0", i, s_ready, en_seen);
    end
    @(posedge wr_clk);
    #1;
    fifo_wr_full = 1'b0;
    @(negedge wr_clk);
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== mk(1'b0, 2'd3, 32'h34333231)) begin
      errors++;
      $display("FAIL full_hold_release: wr_en=%b data=%h required 1/%h", fifo_wr_en, fifo_wr_data, mk(1'b0, 2'd3, 32'h34333231));
    end
    r = s_ready;
    for (int c = 0; c < 20 && i < 8; c++) begin
      if (c != 0) begin
        @(negedge wr_clk);
        r = s_ready;
      end
      @(posedge wr_clk);
      #1;
      if (r) begin
        i++;
        s_data = 8'h31 + 8'(i);
        if (i == 8) s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    tick(4);
    checks++;
    if (i != 8 || wq.size() != 2) begin
      errors++;
      $display("FAIL full_hold_count: accepted=%0d writes=%0d required 8/2", i, wq.size());
    end else begin
      checks++;
      if (wq[0] !== mk(1'b0, 2'd3, 32'h34333231) || wq[1] !== mk(1'b0, 2'd3, 32'h38373635)) begin
        errors++;
        $display("FAIL full_hold_words: got %h %h required %h %h", wq[0], wq[1], mk(1'b0, 2'd3, 32'h34333231), mk(1'b0, 2'd3, 32'h38373635));
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    s_valid  = 1'b0;
    wr_rst_n = 1'b0;
    @(negedge wr_clk);
    checks++;
    if (fifo_wr_en !== 1'b0 || fifo_wr_data !== 35'h0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_outputs: wr_en=%b data=%h ready=%b required 0/0/1", fifo_wr_en, fifo_wr_data, s_ready);
    end
    tick(2);
    wr_rst_n = 1'b1;
    tick(1);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    send(8'h05, 1'b0);
    send(8'h06, 1'b0);
    s_valid = 1'b0;
    tick(4);
    checks++;
    if (wq.size() != 1) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d writes, required 1", wq.size());
    end else begin
      checks++;
      if (wq[0] !== mk(1'b0, 2'd3, 32'h06050403)) begin
        errors++;
        $display("FAIL reset_mid_word: got %h required %h", wq[0], mk(1'b0, 2'd3, 32'h06050403));
      end
    end
  endtask

  task automatic test_timeout();
    clear_log();
    send(8'h5A, 1'b0);
    s_valid = 1'b0;
    tick(10);
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d writes after 10 idle cycles, required 0", wq.size());
    end
    tick(30);
`ifdef FIFO_WR_PACKER_TIMEOUT_EN
    checks++;
    if (wq.size() != 1) begin
      errors++;
      $display("FAIL timeout_count: got %0d writes, required 1", wq.size());
    end else begin
      checks++;
      if (wq[0] !== mk(1'b0, 2'd0, 32'h0000005A)) begin
        errors++;
        $display("FAIL timeout_word: got %h required %h", wq[0], mk(1'b0, 2'd0, 32'h0000005A));
      end
    end
`else
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL timeout_off: got %0d writes, required 0", wq.size());
    end
`endif
    do_reset();
  endtask

  task automatic test_back_to_back();
    clear_log();
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hB3, 1'b0);
    send(8'hB4, 1'b0);
    send(8'h77, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge wr_clk);
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== mk(1'b1, 2'd0, 32'h00000077)) begin
      errors++;
      $display("FAIL b2b_second_live: wr_en=%b data=%h required 1/%h", fifo_wr_en, fifo_wr_data, mk(1'b1, 2'd0, 32'h00000077));
    end
    tick(3);
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes, required 2", wq.size());
    end else begin
      checks++;
      if (wq[0] !== mk(1'b0, 2'd3, 32'hB4B3B2B1) || wq[1] !== mk(1'b1, 2'd0, 32'h00000077)) begin
        errors++;
        $display("FAIL b2b_words: got %h %h required %h %h", wq[0], wq[1], mk(1'b0, 2'd3, 32'hB4B3B2B1), mk(1'b1, 2'd0, 32'h00000077));
      end
      checks++;
      if (wstamp[1] - wstamp[0] != 1) begin
        errors++;
        $display("FAIL b2b_gap: write spacing %0d cycles, required 1", wstamp[1] - wstamp[0]);
      end
    end
  endtask

  initial begin
    wr_rst_n     = 1'b0;
    s_valid      = 1'b0;
    s_data       = 8'h00;
    s_last       = 1'b0;
    fifo_wr_full = 1'b0;
    test_reset();
    test_full_words();
    test_short_last();
    test_full_hold();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
